// File: rtl/cdc_hs_arbiter_if.sv
// Handshake bundle between the N_REQ requesters / slow-domain peer and cdc_hs_arbiter.
// master: the arbiter side; slave: the environment that pulses requests and returns ack.
interface cdc_hs_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req_in;
  logic             xfer_ack_async;
  logic             xfer_req;
  logic [ID_W-1:0]  grant_id;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] pending;
  logic             overflow;
  logic             timeout_err;

  modport master (
    input  req_in, xfer_ack_async,
    output xfer_req, grant_id, done, pending, overflow, timeout_err
  );

  modport slave (
    output req_in, xfer_ack_async,
    input  xfer_req, grant_id, done, pending, overflow, timeout_err
  );
endinterface

// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack channel toward a slower clock domain.
// Optional handshake watchdog enabled with macro CDC_TIMEOUT_EN.
module cdc_hs_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk_fast,
  input  logic               rst_n,
  cdc_hs_arbiter_if.master   bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [ID_W-1:0]        rr_r;
  logic [ID_W-1:0]        grant_id_r;
  logic                   xfer_req_r;
  logic [N_REQ-1:0]       done_r;
  logic [N_REQ-1:0]       pending_r;
  logic                   overflow_r;

  logic                   ack_s;
  logic                   pick_valid_s;
  logic [ID_W-1:0]        pick_idx_s;
  logic [ID_W-1:0]        scan_idx_s;
  logic                   grant_fire_s;
  logic [N_REQ-1:0]       clr_s;
  logic [N_REQ-1:0]       pending_nxt_s;
  logic                   ovf_hit_s;

`ifdef CDC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]          tmo_cnt_r;
  logic                   tmo_hit_s;
  logic                   aborted_r;
  logic                   timeout_err_r;
`endif

  // Ack synchronizer: only the last stage is ever seen by the FSM.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.xfer_ack_async};
    end
  end

  assign ack_s = sync_r[SYNC_STAGES-1];

  // Round-robin pick: first pending bit scanning upward from rr+1 with wrap.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    scan_idx_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx_s = ID_W'((int'(rr_r) + k) % N_REQ);
      if (!pick_valid_s && pending_r[scan_idx_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = scan_idx_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Pending capture: a new event beats the grant clear; a hit on a live bit is dropped.
  always_comb begin
    grant_fire_s = (state_r == ST_IDLE) && !ack_s && pick_valid_s;
    if (grant_fire_s) begin
      clr_s = N_REQ'(1) << pick_idx_s;
    end else begin
      clr_s = '0;
    end
    pending_nxt_s = (pending_r & ~clr_s) | bus.req_in;
    ovf_hit_s     = |(bus.req_in & pending_r & ~clr_s);
  end

`ifdef CDC_TIMEOUT_EN
  assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));
`endif

  // Handshake FSM with all registered outputs.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      rr_r          <= ID_W'(N_REQ - 1);
      grant_id_r    <= '0;
      xfer_req_r    <= 1'b0;
      done_r        <= '0;
      pending_r     <= '0;
      overflow_r    <= 1'b0;
`ifdef CDC_TIMEOUT_EN
      tmo_cnt_r     <= '0;
      aborted_r     <= 1'b0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      done_r     <= '0;
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_r | ovf_hit_s;
`ifdef CDC_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (grant_fire_s) begin
            grant_id_r <= pick_idx_s;
            rr_r       <= pick_idx_s;
            xfer_req_r <= 1'b1;
            state_r    <= ST_REQ;
          end
`ifdef CDC_TIMEOUT_EN
          tmo_cnt_r <= '0;
          aborted_r <= 1'b0;
`endif
        end
        ST_REQ: begin
          if (ack_s) begin
            xfer_req_r <= 1'b0;
            state_r    <= ST_REL;
`ifdef CDC_TIMEOUT_EN
            tmo_cnt_r  <= '0;
          end else if (tmo_hit_s) begin
            xfer_req_r    <= 1'b0;
            timeout_err_r <= 1'b1;
            aborted_r     <= 1'b1;
            state_r       <= ST_REL;
            tmo_cnt_r     <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
`endif
          end
        end
        ST_REL: begin
          if (!ack_s) begin
`ifdef CDC_TIMEOUT_EN
            // An aborted transfer never reports completion.
            if (!aborted_r) begin
              done_r[grant_id_r] <= 1'b1;
            end
            tmo_cnt_r <= '0;
`else
            done_r[grant_id_r] <= 1'b1;
`endif
            state_r <= ST_IDLE;
`ifdef CDC_TIMEOUT_EN
          end else if (tmo_hit_s) begin
            timeout_err_r <= 1'b1;
            state_r       <= ST_IDLE;
            tmo_cnt_r     <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
`endif
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          xfer_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.xfer_req = xfer_req_r;
  assign bus.grant_id = grant_id_r;
  assign bus.done     = done_r;
  assign bus.pending  = pending_r;
  assign bus.overflow = overflow_r;
`ifdef CDC_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_r;
`else
  // No watchdog in this build; the parameter is still referenced so both builds share one port list.
  assign bus.timeout_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Directed self-checking bench for cdc_hs_arbiter with a delayed-echo slow-side ack model.
module tb_cdc_hs_arbiter;
  localparam int N_REQ       = 4;
  localparam int SYNC_STAGES = 3;
  localparam int TIMEOUT_CYC = 16;

  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  logic rst_n    = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic       ack_manual = 1'b0;
  logic       ack_force  = 1'b0;
  logic [4:0] slow_pipe  = 5'd0;
  logic       prev_xreq  = 1'b0;

  logic [N_REQ-1:0] done_log [$];
  int               grant_log [$];

  cdc_hs_arbiter_if #(.N_REQ(N_REQ)) bus ();

  cdc_hs_arbiter #(
    .N_REQ      (N_REQ),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_fast(clk_fast),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_fast = ~clk_fast;
  initial begin
    #3;
    forever #17 clk_slow = ~clk_slow;
  end

  // Slow-side peer: echoes xfer_req after five slow cycles unless overridden.
  always @(posedge clk_slow) slow_pipe <= {slow_pipe[3:0], bus.xfer_req};
  assign bus.xfer_ack_async = ack_manual ? ack_force : slow_pipe[4];

  // Monitor: logs done pulses and the grant id at each xfer_req rise.
  always @(negedge clk_fast) begin
    if (bus.done != '0) done_log.push_back(bus.done);
    if (bus.xfer_req && !prev_xreq) grant_log.push_back(int'(bus.grant_id));
    prev_xreq = bus.xfer_req;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req_in = '0;
    ack_manual = 1'b0;
    ack_force  = 1'b0;
    repeat (30) tick();
    rst_n = 1'b1;
    tick();
    done_log.delete();
    grant_log.delete();
  endtask

  task automatic pulse(input logic [N_REQ-1:0] v);
    bus.req_in = v;
    tick();
    bus.req_in = '0;
  endtask

  task automatic wait_dones(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (done_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq({tag, "_done_cnt"}, done_log.size(), n);
  endtask

  function automatic int grant_at(input int i);
    return (grant_log.size() > i) ? grant_log[i] : -1;
  endfunction

  function automatic logic [N_REQ-1:0] done_at(input int i);
    return (done_log.size() > i) ? done_log[i] : '0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_in = '0;
    repeat (3) tick();

    // Reset values
    check_eq("rst_xfer_req", bus.xfer_req, 0);
    check_eq("rst_grant_id", bus.grant_id, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_pending", bus.pending, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    check_eq("rst_timeout", bus.timeout_err, 0);

    // Single event on requester 1
    do_reset();
    pulse(4'b0010);
    check_eq("single_pend", bus.pending, 4'b0010);
    check_eq("single_xreq_k1", bus.xfer_req, 0);
    tick();
    check_eq("single_xreq_k2", bus.xfer_req, 1);
    check_eq("single_gid", bus.grant_id, 1);
    check_eq("single_pend_clr", bus.pending, 0);
    wait_dones("single", 1, 300);
    repeat (60) tick();
    check_eq("single_once", done_log.size(), 1);
    check_eq("single_done", done_at(0), 4'b0010);
    check_eq("single_pend_end", bus.pending, 0);

    // Round-robin from reset
    do_reset();
    pulse(4'b1111);
    wait_dones("rr", 4, 800);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_grant%0d", i), grant_at(i), i);
      check_eq($sformatf("rr_done%0d", i), done_at(i), 4'b0001 << i);
    end
    check_eq("rr_overflow", bus.overflow, 0);

    // Rotation fairness: after 2, pending {0,2} goes 0 then 2
    do_reset();
    pulse(4'b0100);
    tick();
    check_eq("fair_gid2", bus.grant_id, 2);
    pulse(4'b0101);
    wait_dones("fair", 3, 900);
    check_eq("fair_g0", grant_at(0), 2);
    check_eq("fair_g1", grant_at(1), 0);
    check_eq("fair_g2", grant_at(2), 2);

    // Overflow: 3 hit twice while pending behind grant 0
    do_reset();
    pulse(4'b0001);
    tick();
    pulse(4'b1000);
    tick();
    check_eq("ovf_before", bus.overflow, 0);
    pulse(4'b1000);
    check_eq("ovf_set", bus.overflow, 1);
    check_eq("ovf_pend", bus.pending, 4'b1000);
    wait_dones("ovf", 2, 600);
    repeat (80) tick();
    check_eq("ovf_done_cnt_end", done_log.size(), 2);
    check_eq("ovf_done3", done_at(1), 4'b1000);
    check_eq("ovf_sticky", bus.overflow, 1);

    // Same-cycle re-request at grant time keeps pending, no overflow
    do_reset();
    bus.req_in = 4'b1000;
    tick();
    tick();
    bus.req_in = '0;
    check_eq("same_xreq", bus.xfer_req, 1);
    check_eq("same_gid", bus.grant_id, 3);
    check_eq("same_pend", bus.pending, 4'b1000);
    check_eq("same_ovf", bus.overflow, 0);
    wait_dones("same", 2, 600);
    check_eq("same_g1", grant_at(1), 3);

    // Latency through the ack synchronizer, manual ack
    do_reset();
    ack_manual = 1'b1;
    pulse(4'b0001);
    tick();
    check_eq("lat_xreq_up", bus.xfer_req, 1);
    ack_force = 1'b1;
    repeat (SYNC_STAGES) tick();
    check_eq("lat_xreq_hold", bus.xfer_req, 1);
    tick();
    check_eq("lat_xreq_fall", bus.xfer_req, 0);
    ack_force = 1'b0;
    repeat (SYNC_STAGES) tick();
    check_eq("lat_done_early", bus.done, 0);
    tick();
    check_eq("lat_done", bus.done, 4'b0001);
    tick();
    check_eq("lat_done_once", bus.done, 0);

    // ack high in IDLE blocks grants until it drops
    ack_force = 1'b1;
    repeat (5) tick();
    pulse(4'b0010);
    repeat (5) tick();
    check_eq("viol_no_grant", bus.xfer_req, 0);
    check_eq("viol_pend", bus.pending, 4'b0010);
    ack_force = 1'b0;
    repeat (SYNC_STAGES) tick();
    check_eq("viol_still_low", bus.xfer_req, 0);
    tick();
    check_eq("viol_grant", bus.xfer_req, 1);
    check_eq("viol_gid", bus.grant_id, 1);

    // Asynchronous reset in the middle of REQ
    do_reset();
    ack_manual = 1'b1;
    pulse(4'b0011);
    tick();
    pulse(4'b0010);
    check_eq("mid_pre_xreq", bus.xfer_req, 1);
    check_eq("mid_pre_ovf", bus.overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_xreq", bus.xfer_req, 0);
    check_eq("mid_gid", bus.grant_id, 0);
    check_eq("mid_pend", bus.pending, 0);
    check_eq("mid_ovf", bus.overflow, 0);
    check_eq("mid_done", bus.done, 0);

    // Watchdog behaviour with ack never rising
    do_reset();
    ack_manual = 1'b1;
    pulse(4'b0100);
    tick();
    n = 0;
`ifdef CDC_TIMEOUT_EN
    while (bus.xfer_req && n < 100) begin
      n++;
      tick();
    end
    check_eq("tmo_cycles", n, TIMEOUT_CYC);
    check_eq("tmo_pulse", bus.timeout_err, 1);
    tick();
    check_eq("tmo_pulse_end", bus.timeout_err, 0);
    repeat (20) tick();
    check_eq("tmo_no_done", done_log.size(), 0);
    check_eq("tmo_xreq", bus.xfer_req, 0);
`else
    while (bus.xfer_req && n < 1100) begin
      n++;
      tick();
    end
    check_eq("notmo_hold", n, 1100);
    check_eq("notmo_err", bus.timeout_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdc_hs_arbiter.md
Name: cdc_hs_arbiter

Overview:
- Fast-domain controller that shares one single-bit level req/ack handshake channel toward a slower clock domain between N_REQ requesters.
- Captures one-cycle event pulses, arbitrates round-robin, and drives a four-phase handshake.
- Provides a stable grant_id that the slow side samples once it sees xfer_req.
- Synchronizes the returning ack internally and reports per-requester completion.

Parameters:
N_REQ, 4, number of requesters (2..16); ID_W = clog2(N_REQ) derived localparam
SYNC_STAGES, 3, flops in the xfer_ack_async synchronizer (>=2)
TIMEOUT_CYC, 255, handshake-phase timeout in clk_fast cycles (used only with CDC_TIMEOUT_EN)

Ports:
clk_fast  in  1  fast-domain clock; single clock for the whole block
rst_n  in  1  asynchronous active-low reset
req_in  in  N_REQ  one-cycle event pulses, one bit per requester
xfer_ack_async  in  1  ack level from slow domain; asynchronous to clk_fast
xfer_req  out  1  handshake request level to slow domain; registered
grant_id  out  ID_W  index of granted requester; registered; stable whenever xfer_req=1
done  out  N_REQ  one-cycle pulse on the granted bit when its handshake completes
pending  out  N_REQ  captured, not-yet-granted events
overflow  out  1  sticky; set when req_in hits an already-pending bit; cleared only by reset
timeout_err  out  1  one-cycle pulse on handshake timeout; constant 0 without CDC_TIMEOUT_EN

Behaviour:
- Reset (async assert, released synchronously by flops): state=IDLE; xfer_req=0, grant_id=0, done=0, pending=0, overflow=0, timeout_err=0; sync chain=0; rr pointer=N_REQ-1, so requester 0 has priority first.
- Ack sync: ack_s = last stage of the SYNC_STAGES shift chain on xfer_ack_async. The FSM uses only ack_s.
- Pending capture: pending[i] sets on req_in[i], clears when i is granted.
  - If the set and clear coincide, set wins and pending[i] stays 1 (a new event).
  - If req_in[i] arrives while pending[i]=1 and it is not being cleared that cycle, the event is dropped and overflow is set.
- FSM states: IDLE, REQ, REL.
  - IDLE: if pending!=0, pick the first set bit scanning from rr+1 upward with wrap. Register grant_id and rr to that index, clear its pending bit, set xfer_req=1, go to REQ. All of this happens on the same edge.
  - REQ: hold xfer_req=1 until ack_s=1. Then xfer_req<=0 and go to REL.
  - REL: wait for ack_s=0. Then pulse done[grant_id] for one cycle and go to IDLE. grant_id holds its value.
- Latency:
  - req_in pulse at edge k -> pending at k+1 -> xfer_req=1 at k+2 (if IDLE).
  - ack rising at slow side -> xfer_req falls SYNC_STAGES+1 edges later.
  - Back-to-back: a new grant can occur on the edge after done pulses, since REL->IDLE->REQ takes 2 edges.
- ack_s=1 seen in IDLE (protocol violation): ignored. No grant until ack_s=0.
- Reset mid-transfer: xfer_req drops immediately; all pending events are lost. The slow side must tolerate an aborted request.

Optional Feature:
- Macro: CDC_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on every state change and increments in REQ and REL.
  - Reaching TIMEOUT_CYC in REQ: pulse timeout_err, drop xfer_req, go to REL.
  - Reaching TIMEOUT_CYC in REL: pulse timeout_err, go to IDLE without a done pulse. The counter then restarts.
- When undefined: no counter, the FSM waits indefinitely, and timeout_err is tied 0.

Test Plan:
- Single event: req_in=4'b0010 for 1 cycle; ack model echoes xfer_req after 5 slow cycles. Expect grant_id=1, xfer_req=1 two edges after the pulse, done=4'b0010 exactly once, pending=0 at end.
- Round-robin: req_in=4'b1111 in one cycle. Expect grant order 0,1,2,3, four done pulses, no overflow.
- Rotation fairness: after granting 2, pulse req_in=4'b0101. Expect the next grant to be 0, then 2.
- Overflow: req_in[3] pulsed twice while 3 is pending behind an active grant. Expect overflow=1 sticky and only one done[3]. Same-cycle re-request at grant time keeps pending[3]=1 with no overflow.
- Reset mid-REQ: assert rst_n=0 while xfer_req=1. Expect xfer_req=0 asynchronously and all outputs at reset values.
- With CDC_TIMEOUT_EN and TIMEOUT_CYC=16, ack never rises. Expect timeout_err pulse at 16 cycles in REQ, xfer_req=0, return to IDLE, no done. Without the macro, xfer_req stays 1 for more than 1000 cycles.
